comp_result_accumulator: RTL



---
 rtl/comp_acc_pkg.sv | 24 ++
 rtl/comp_sample_classifier.sv | 31 +++
 rtl/comp_result_accumulator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/comp_acc_pkg.sv
// Shared types and elaboration helpers for the comparator result accumulator.
package comp_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_ONE,
    CLS_INVALID
  } cls_t;

  // True when a window of win samples is non-empty and fits in a cnt_w-bit count.
  function automatic bit win_fits(input int cnt_w, input int win);
    longint lim;
    lim = (longint'(1) << cnt_w) - 1;
    return (win >= 1) && (longint'(win) <= lim);
  endfunction

endpackage

// File: rtl/comp_sample_classifier.sv
// Registers the comparator output pair and decodes it as ONE, ZERO or INVALID.
module comp_sample_classifier
  import comp_acc_pkg::*;
(
  input  logic clk_comp,
  input  logic voutp,
  input  logic voutm,
  output cls_t cls,
  output logic valid
);

  logic sp;
  logic sm;

  // No reset: the pair is re-captured every cycle and only looked at while busy.
  always_ff @(posedge clk_comp) begin
    sp <= voutp;
    sm <= voutm;
  end

  always_comb begin
    cls = CLS_INVALID;
    if (sp && !sm)
      cls = CLS_ONE;
    else if (!sp && sm)
      cls = CLS_ZERO;
  end

  assign valid = sp ^ sm;

endmodule

// File: rtl/comp_result_accumulator.sv
// Comparator decision accumulator: settle, count a window of classified samples, report majority.
// Optional COMP_ACC_RUNLEN_EN adds MAXRUN, the longest run of identical valid decisions.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for START, counts cleared
//   ST_SETTLE | discarding SETTLE registered samples
//   ST_ACCUM  | counting WIN registered samples into ONES/ZEROS/INVALID
//   ST_DONE   | counts and RESULT frozen, DONE high until START or RST
module comp_result_accumulator
  import comp_acc_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WIN    = 200,
  parameter int SETTLE = 4
) (
  input  logic             CLK_COMP,
  input  logic             RST,
  input  logic             START,
  input  logic             VOUTP,
  input  logic             VOUTM,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ONES,
  output logic [CNT_W-1:0] ZEROS,
  output logic [CNT_W-1:0] INVALID,
  output logic             RESULT
`ifdef COMP_ACC_RUNLEN_EN
  ,
  output logic [CNT_W-1:0] MAXRUN
`endif
);

  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  if (!win_fits(CNT_W, WIN)) begin : g_win_chk
    $error("comp_result_accumulator: WIN must be in 1..2^CNT_W-1");
  end

  state_t             state;
  cls_t               cls;
  logic               valid;
  logic               start_ok;
  logic               inc_one;
  logic               inc_zero;
  logic               inc_inv;
  logic [CNT_W-1:0]   ones_q;
  logic [CNT_W-1:0]   zeros_q;
  logic [CNT_W-1:0]   inv_q;
  logic [CNT_W-1:0]   ones_nxt;
  logic [CNT_W-1:0]   zeros_nxt;
  logic [CNT_W-1:0]   wnd_left;
  logic [SET_W-1:0]   settle_left;
  logic               busy_q;
  logic               done_q;
  logic               result_q;

  comp_sample_classifier u_cls (
    .clk_comp (CLK_COMP),
    .voutp    (VOUTP),
    .voutm    (VOUTM),
    .cls      (cls),
    .valid    (valid)
  );

  // START is honoured only when no measurement is in flight.
  assign start_ok  = START && ((state == ST_IDLE) || (state == ST_DONE));
  assign inc_one   = valid && (cls == CLS_ONE);
  assign inc_zero  = valid && (cls == CLS_ZERO);
  assign inc_inv   = !valid;
  assign ones_nxt  = ones_q + CNT_W'(inc_one);
  assign zeros_nxt = zeros_q + CNT_W'(inc_zero);

  always_ff @(posedge CLK_COMP) begin
    if (RST) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      ones_q      <= '0;
      zeros_q     <= '0;
      inv_q       <= '0;
      wnd_left    <= '0;
      settle_left <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            ones_q      <= '0;
            zeros_q     <= '0;
            inv_q       <= '0;
            wnd_left    <= CNT_W'(WIN);
            settle_left <= SET_W'(SETTLE);
            state       <= (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_left <= settle_left - SET_W'(1);
          if (settle_left == SET_W'(1))
            state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          ones_q   <= ones_nxt;
          zeros_q  <= zeros_nxt;
          inv_q    <= inv_q + CNT_W'(inc_inv);
          wnd_left <= wnd_left - CNT_W'(1);
          if (wnd_left == CNT_W'(1)) begin
            state    <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= (ones_nxt > zeros_nxt);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ONES    = ones_q;
  assign ZEROS   = zeros_q;
  assign INVALID = inv_q;
  assign RESULT  = result_q;

`ifdef COMP_ACC_RUNLEN_EN
  logic [CNT_W-1:0] run_cur;
  logic [CNT_W-1:0] run_max;
  logic [CNT_W-1:0] run_nxt;
  cls_t             run_cls;

  // An INVALID sample breaks the run; a class change restarts it at one.
  always_comb begin
    run_nxt = '0;
    if (valid)
      run_nxt = ((run_cur != '0) && (cls == run_cls)) ? run_cur + CNT_W'(1) : CNT_W'(1);
  end

  always_ff @(posedge CLK_COMP) begin
    if (RST || start_ok) begin
      run_cur <= '0;
      run_max <= '0;
      run_cls <= CLS_ZERO;
    end else if (state == ST_ACCUM) begin
      run_cur <= run_nxt;
      run_cls <= cls;
      if (run_nxt > run_max)
        run_max <= run_nxt;
    end
  end

  assign MAXRUN = run_max;
`endif

endmodule
